// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared integer register file sizing and basic typedefs.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = $clog2(NUM_REGS);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       word_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : rf_scoreboard
//  Description : Per-register busy scoreboard. ID marks a destination busy at
//                issue, WB clears it on write. Produces the RAW/WAW stall.
//  Config      : REGFILE_BYPASS_EN - a register being written back this cycle
//                is not considered busy (its value is forwarded by the top).
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                rs1/rs2_addr_i      - ID source addresses
//                wb_reg_we_i/addr_i  - write-back enable and destination
//                issue_*_i           - issuing instruction attributes
//                hazard_stall_o      - ID must hold this cycle
//                busy_vec_o          - registered busy bits (bit 0 always 0)
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_scoreboard
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  reg_addr_t           rs1_addr_i,
  input  reg_addr_t           rs2_addr_i,
  input  logic                wb_reg_we_i,
  input  reg_addr_t           wb_rd_addr_i,
  input  logic                issue_valid_i,
  input  logic                issue_rd_we_i,
  input  reg_addr_t           issue_rd_addr_i,
  input  logic                issue_rs1_used_i,
  input  logic                issue_rs2_used_i,
  output logic                hazard_stall_o,
  output logic [NUM_REGS-1:0] busy_vec_o
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_clear;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_busy_eff;
  logic                w_raw1;
  logic                w_raw2;
  logic                w_waw;
  logic                w_issue_wr;

  // Clear decode kept in its own block: the stall depends on it and the set
  // decode depends on the stall.
  always_comb begin
    w_clear = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      w_clear[r] = wb_reg_we_i && (wb_rd_addr_i == reg_addr_t'(r));
    end
  end

`ifdef REGFILE_BYPASS_EN
  // The value arrives through the read bypass, so the register is free now.
  assign w_busy_eff = r_busy & ~w_clear;
`else
  assign w_busy_eff = r_busy;
`endif

  assign w_raw1 = issue_rs1_used_i && w_busy_eff[rs1_addr_i];
  assign w_raw2 = issue_rs2_used_i && w_busy_eff[rs2_addr_i];
  assign w_waw  = issue_rd_we_i    && w_busy_eff[issue_rd_addr_i];

  assign hazard_stall_o = issue_valid_i && !rst && (w_raw1 || w_raw2 || w_waw);

  assign w_issue_wr = issue_valid_i && issue_rd_we_i && !hazard_stall_o;

  // x0 never becomes busy: bit 0 of the set vector stays 0.
  always_comb begin
    w_set = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      w_set[r] = w_issue_wr && (issue_rd_addr_i == reg_addr_t'(r));
    end
  end

  // Set is OR-ed in after the clear so a new producer wins over a retiring one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clear) | w_set;
    end
  end

  assign busy_vec_o = r_busy;

endmodule : rf_scoreboard
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Integer register file (x0 hardwired to zero) with two
//                combinational ID read ports, one WB write port and a busy
//                scoreboard generating the ID hazard stall.
//  Config      : REGFILE_BYPASS_EN - same-cycle WB data is forwarded to the
//                read ports and a retiring register no longer stalls ID.
//  Ports       : clk, rst             - clock, synchronous active-high reset
//                rs1/rs2_addr_i       - read addresses
//                rs1/rs2_data_o       - read data (combinational)
//                wb_reg_we_i/rd_addr_i/rd_data_i - write-back port
//                issue_*_i            - issuing instruction attributes
//                hazard_stall_o       - ID must hold this cycle
//                busy_vec_o           - registered busy bits
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  reg_addr_t           rs1_addr_i,
  input  reg_addr_t           rs2_addr_i,
  output word_t               rs1_data_o,
  output word_t               rs2_data_o,
  input  logic                wb_reg_we_i,
  input  reg_addr_t           wb_rd_addr_i,
  input  word_t               wb_rd_data_i,
  input  logic                issue_valid_i,
  input  logic                issue_rd_we_i,
  input  reg_addr_t           issue_rd_addr_i,
  input  logic                issue_rs1_used_i,
  input  logic                issue_rs2_used_i,
  output logic                hazard_stall_o,
  output logic [NUM_REGS-1:0] busy_vec_o
);

  word_t r_mem [NUM_REGS];
  logic  w_wb_wr;

  assign w_wb_wr = wb_reg_we_i && (wb_rd_addr_i != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wb_wr) begin
      r_mem[wb_rd_addr_i] <= wb_rd_data_i;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic w_hit1;
  logic w_hit2;
  assign w_hit1 = w_wb_wr && (wb_rd_addr_i == rs1_addr_i);
  assign w_hit2 = w_wb_wr && (wb_rd_addr_i == rs2_addr_i);
`endif

  // Later assignments take priority: x0 / reset zeroing overrides the bypass.
  always_comb begin
    rs1_data_o = r_mem[rs1_addr_i];
`ifdef REGFILE_BYPASS_EN
    if (w_hit1) rs1_data_o = wb_rd_data_i;
`endif
    if (rst || (rs1_addr_i == '0)) rs1_data_o = '0;
  end

  always_comb begin
    rs2_data_o = r_mem[rs2_addr_i];
`ifdef REGFILE_BYPASS_EN
    if (w_hit2) rs2_data_o = wb_rd_data_i;
`endif
    if (rst || (rs2_addr_i == '0)) rs2_data_o = '0;
  end

  rf_scoreboard u_sb (
    .clk              (clk),
    .rst              (rst),
    .rs1_addr_i       (rs1_addr_i),
    .rs2_addr_i       (rs2_addr_i),
    .wb_reg_we_i      (wb_reg_we_i),
    .wb_rd_addr_i     (wb_rd_addr_i),
    .issue_valid_i    (issue_valid_i),
    .issue_rd_we_i    (issue_rd_we_i),
    .issue_rd_addr_i  (issue_rd_addr_i),
    .issue_rs1_used_i (issue_rs1_used_i),
    .issue_rs2_used_i (issue_rs2_used_i),
    .hazard_stall_o   (hazard_stall_o),
    .busy_vec_o       (busy_vec_o)
  );

endmodule : regfile_scoreboard
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_scoreboard
//  Description : Self-checking bench for regfile_scoreboard. Directed cases
//                followed by random traffic, all checked against a reference
//                model of the architectural register and pending-write state.
//  Config      : REGFILE_BYPASS_EN selects the expected forwarding behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;
  import cpu_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit c_byp = 1'b1;
`else
  localparam bit c_byp = 1'b0;
`endif

  logic                clk;
  logic                rst;
  reg_addr_t           rs1_addr_i, rs2_addr_i;
  word_t               rs1_data_o, rs2_data_o;
  logic                wb_reg_we_i;
  reg_addr_t           wb_rd_addr_i;
  word_t               wb_rd_data_i;
  logic                issue_valid_i, issue_rd_we_i;
  reg_addr_t           issue_rd_addr_i;
  logic                issue_rs1_used_i, issue_rs2_used_i;
  logic                hazard_stall_o;
  logic [NUM_REGS-1:0] busy_vec_o;

  regfile_scoreboard dut (
    .clk              (clk),
    .rst              (rst),
    .rs1_addr_i       (rs1_addr_i),
    .rs2_addr_i       (rs2_addr_i),
    .rs1_data_o       (rs1_data_o),
    .rs2_data_o       (rs2_data_o),
    .wb_reg_we_i      (wb_reg_we_i),
    .wb_rd_addr_i     (wb_rd_addr_i),
    .wb_rd_data_i     (wb_rd_data_i),
    .issue_valid_i    (issue_valid_i),
    .issue_rd_we_i    (issue_rd_we_i),
    .issue_rd_addr_i  (issue_rd_addr_i),
    .issue_rs1_used_i (issue_rs1_used_i),
    .issue_rs2_used_i (issue_rs2_used_i),
    .hazard_stall_o   (hazard_stall_o),
    .busy_vec_o       (busy_vec_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: architectural values and "a write is still outstanding".
  logic [31:0] m_val     [NUM_REGS];
  bit          m_pending [NUM_REGS];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    rst = 0; rs1_addr_i = '0; rs2_addr_i = '0;
    wb_reg_we_i = 0; wb_rd_addr_i = '0; wb_rd_data_i = '0;
    issue_valid_i = 0; issue_rd_we_i = 0; issue_rd_addr_i = '0;
    issue_rs1_used_i = 0; issue_rs2_used_i = 0;
  endtask

  function automatic logic [31:0] m_read(int a);
    if (rst || a == 0) return 32'h0;
    if (c_byp && wb_reg_we_i && int'(wb_rd_addr_i) == a) return wb_rd_data_i;
    return m_val[a];
  endfunction

  // A register blocks ID while its write is outstanding; with forwarding the
  // write-back cycle itself already delivers the value.
  function automatic bit m_blocks(int a);
    if (a == 0 || !m_pending[a]) return 1'b0;
    if (c_byp && wb_reg_we_i && int'(wb_rd_addr_i) == a) return 1'b0;
    return 1'b1;
  endfunction

  // Checks all outputs against the model, advances the model, then one clock.
  task automatic step();
    bit                  e_stall;
    logic [NUM_REGS-1:0] e_busy;
    e_stall = issue_valid_i && !rst &&
              ((issue_rs1_used_i && m_blocks(int'(rs1_addr_i))) ||
               (issue_rs2_used_i && m_blocks(int'(rs2_addr_i))) ||
               (issue_rd_we_i    && m_blocks(int'(issue_rd_addr_i))));
    for (int r = 0; r < NUM_REGS; r++) e_busy[r] = m_pending[r];
    chk("rs1_data", rs1_data_o, m_read(int'(rs1_addr_i)));
    chk("rs2_data", rs2_data_o, m_read(int'(rs2_addr_i)));
    chk("stall", hazard_stall_o, e_stall);
    chk("busy_vec", busy_vec_o, e_busy);
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        m_val[r] = 0; m_pending[r] = 0;
      end
    end else begin
      if (wb_reg_we_i && wb_rd_addr_i != 0) begin
        m_val[wb_rd_addr_i]     = wb_rd_data_i;
        m_pending[wb_rd_addr_i] = 0;
      end
      if (issue_valid_i && issue_rd_we_i && !e_stall && issue_rd_addr_i != 0)
        m_pending[issue_rd_addr_i] = 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int r = 0; r < NUM_REGS; r++) begin
      m_val[r] = 0; m_pending[r] = 0;
    end
    idle(); rst = 1;
    @(negedge clk);

    // Reset cycle, then all registers read zero
    idle(); rst = 1; rs1_addr_i = 5'd3; #1;
    chk("rst_rs1_zero", rs1_data_o, 0);
    chk("rst_stall0", hazard_stall_o, 0);
    step();
    for (int i = 1; i < NUM_REGS; i++) begin
      idle(); rs1_addr_i = reg_addr_t'(i); rs2_addr_i = reg_addr_t'(NUM_REGS - i); #1;
      chk("init_zero", rs1_data_o, 0);
      step();
    end

    // Write to x0 is dropped
    idle(); wb_reg_we_i = 1; wb_rd_addr_i = 0; wb_rd_data_i = 32'hDEADBEEF; #1;
    step();
    idle(); #1;
    chk("x0_zero", rs1_data_o, 0);
    step();

    // Write x5 while reading it
    idle(); wb_reg_we_i = 1; wb_rd_addr_i = 5; wb_rd_data_i = 32'h12345678; rs1_addr_i = 5; #1;
    chk("x5_same_cycle", rs1_data_o, c_byp ? 32'h12345678 : 32'h0);
    step();
    idle(); rs1_addr_i = 5; #1;
    chk("x5_next_cycle", rs1_data_o, 32'h12345678);
    step();

    // RAW on x7
    idle(); issue_valid_i = 1; issue_rd_we_i = 1; issue_rd_addr_i = 7; #1;
    chk("issue7_nostall", hazard_stall_o, 0);
    step();
    for (int k = 0; k < 2; k++) begin
      idle(); issue_valid_i = 1; rs2_addr_i = 7; issue_rs2_used_i = 1; #1;
      chk("raw7_stall", hazard_stall_o, 1);
      chk("busy7_set", busy_vec_o[7], 1);
      step();
    end
    idle(); issue_valid_i = 1; rs2_addr_i = 7; issue_rs2_used_i = 1;
    wb_reg_we_i = 1; wb_rd_addr_i = 7; wb_rd_data_i = 32'hCAFE0007; #1;
    chk("raw7_wb_cycle", hazard_stall_o, c_byp ? 1'b0 : 1'b1);
    step();
    idle(); issue_valid_i = 1; rs2_addr_i = 7; issue_rs2_used_i = 1; #1;
    chk("raw7_after", hazard_stall_o, 0);
    chk("busy7_clear", busy_vec_o[7], 0);
    chk("x7_data", rs2_data_o, 32'hCAFE0007);
    step();

    // WB clear and new issue of x9 in the same cycle
    idle(); issue_valid_i = 1; issue_rd_we_i = 1; issue_rd_addr_i = 9; #1;
    step();
    idle(); issue_valid_i = 1; issue_rd_we_i = 1; issue_rd_addr_i = 9;
    wb_reg_we_i = 1; wb_rd_addr_i = 9; wb_rd_data_i = 32'h99; #1;
    chk("waw9_stall", hazard_stall_o, c_byp ? 1'b0 : 1'b1);
    step();
    idle(); issue_valid_i = 1; issue_rd_we_i = 1; issue_rd_addr_i = 9; #1;
    chk("busy9_after", busy_vec_o[9], c_byp ? 1'b1 : 1'b0);
    chk("retry9_stall", hazard_stall_o, c_byp ? 1'b1 : 1'b0);
    step();
    idle(); wb_reg_we_i = 1; wb_rd_addr_i = 9; wb_rd_data_i = 32'h999; #1;
    step();
    idle(); #1;
    chk("busy9_final", busy_vec_o[9], 0);
    step();

    // Reset drops pending state and data
    idle(); issue_valid_i = 1; issue_rd_we_i = 1; issue_rd_addr_i = 3;
    wb_reg_we_i = 1; wb_rd_addr_i = 3; wb_rd_data_i = 32'hA5A5A5A5; #1;
    chk("issue3_nostall", hazard_stall_o, 0);
    step();
    idle(); rst = 1; rs1_addr_i = 3; issue_valid_i = 1; issue_rs1_used_i = 1; #1;
    chk("busy3_pre_rst", busy_vec_o[3], 1);
    chk("rst_no_stall", hazard_stall_o, 0);
    step();
    idle(); rs1_addr_i = 3; issue_valid_i = 1; issue_rs1_used_i = 1; #1;
    chk("busy_after_rst", busy_vec_o, 0);
    chk("x3_after_rst", rs1_data_o, 0);
    chk("x3_issue_nostall", hazard_stall_o, 0);
    step();

    // No issue: no stall, no busy change
    idle(); issue_valid_i = 1; issue_rd_we_i = 1; issue_rd_addr_i = 4; #1;
    step();
    idle(); rs1_addr_i = 4; issue_rs1_used_i = 1; issue_rd_we_i = 1; issue_rd_addr_i = 6; #1;
    chk("novalid_stall", hazard_stall_o, 0);
    step();
    idle(); #1;
    chk("novalid_busy4", busy_vec_o[4], 1);
    chk("novalid_busy6", busy_vec_o[6], 0);
    step();
    idle(); wb_reg_we_i = 1; wb_rd_addr_i = 4; wb_rd_data_i = 32'h4; #1;
    step();

    // Random traffic concentrated on a few registers to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      idle();
      rst              = ($urandom_range(0, 99) == 0);
      rs1_addr_i       = reg_addr_t'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
      rs2_addr_i       = reg_addr_t'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
      wb_reg_we_i      = $urandom_range(0, 1) == 1;
      wb_rd_addr_i     = reg_addr_t'($urandom_range(0, 7));
      wb_rd_data_i     = $urandom;
      issue_valid_i    = $urandom_range(0, 9) < 7;
      issue_rd_we_i    = $urandom_range(0, 1) == 1;
      issue_rd_addr_i  = reg_addr_t'($urandom_range(0, 7));
      issue_rs1_used_i = $urandom_range(0, 1) == 1;
      issue_rs2_used_i = $urandom_range(0, 1) == 1;
      #1;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_regfile_scoreboard
`default_nettype wire
